// File: rtl/serial_tx_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : serial_tx_scheduler                                           |
// | Function : round-robin arbiter feeding one shift-register serializer;    |
// |            generates load, data-valid, done and optional parity timing.  |
// | Options  : PARITY_EN adds a trailing even-parity frame bit.              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module serial_tx_scheduler #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 3,
  parameter int GAP    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic                      ser_load,
  output logic [DATA_W-1:0]         ser_din,
  output logic                      ser_dv,
  output logic [$clog2(N_REQ)-1:0]  gnt_id,
  output logic                      busy,
  output logic                      done,
  output logic                      par_sel,
  output logic                      par_bit
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_PAR   = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     gnt_q, gnt_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                dv_q, dv_d;
  logic                done_q, done_d;
  logic                par_sel_q, par_sel_d;
  logic                par_bit_q, par_bit_d;

  logic                arb_found;
  logic [ID_W-1:0]     arb_win;
  logic [ID_W-1:0]     arb_cand;
  logic [DATA_W-1:0]   arb_word;
  logic                arb_go;
  logic                frame_end;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    arb_cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      arb_cand = ID_W'((int'(ptr_q) + i) % N_REQ);
      if (!arb_found && req[arb_cand]) begin
        arb_found = 1'b1;
        arb_win   = arb_cand;
      end
    end
    arb_word = req_data[int'(arb_win)*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    din_d     = din_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    arb_go    = 1'b0;
    frame_end = 1'b0;

    case (state_q)
      S_IDLE:  arb_go = 1'b1;
      S_LOAD: begin
        state_d = S_SHIFT;
        bit_d   = '0;
      end
      S_SHIFT: begin
        if (bit_q == LAST_BIT) begin
`ifdef PARITY_EN
          state_d = S_PAR;
`else
          frame_end = 1'b1;
`endif
        end else begin
          bit_d = bit_q + CNT_W'(1);
        end
      end
      S_PAR:   frame_end = 1'b1;
      S_GAP: begin
        if (gap_q == LAST_GAP) state_d = S_IDLE;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // With no gap the next frame is arbitrated in the final frame cycle.
    if (frame_end) begin
      if (GAP > 0) begin
        state_d = S_GAP;
        gap_d   = '0;
      end else begin
        state_d = S_IDLE;
        arb_go  = 1'b1;
      end
    end

    if (arb_go && arb_found) begin
      state_d = S_LOAD;
      ptr_d   = arb_win;
      gnt_d   = arb_win;
      din_d   = arb_word;
    end

    dv_d = (state_q == S_SHIFT) || (state_q == S_PAR);
`ifdef PARITY_EN
    done_d    = (state_q == S_PAR);
    par_sel_d = (state_q == S_PAR);
    par_bit_d = (state_q == S_PAR) && (^din_q);
`else
    done_d    = (state_q == S_SHIFT) && (bit_q == LAST_BIT);
    par_sel_d = 1'b0;
    par_bit_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= ID_W'(N_REQ - 1);
      gnt_q     <= '0;
      din_q     <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      dv_q      <= 1'b0;
      done_q    <= 1'b0;
      par_sel_q <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      din_q     <= din_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      dv_q      <= dv_d;
      done_q    <= done_d;
      par_sel_q <= par_sel_d;
      par_bit_q <= par_bit_d;
    end
  end

  assign ser_load = (state_q == S_LOAD);
  assign ack      = (state_q == S_LOAD) ? (ONE_HOT0 << gnt_q) : '0;
  assign busy     = (state_q != S_IDLE);
  assign ser_din  = din_q;
  assign gnt_id   = gnt_q;
  assign ser_dv   = dv_q;
  assign done     = done_q;
  assign par_sel  = par_sel_q;
  assign par_bit  = par_bit_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_scheduler.sv
`default_nettype none
// Directed bench for serial_tx_scheduler (N_REQ=4, DATA_W=3, GAP=1),
// with a small MSB-first serializer model hung on ser_load/ser_din.
module tb_serial_tx_scheduler;

  localparam int DW = 3;
  localparam int GP = 1;
`ifdef PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LAST_DV  = DW + 1 + PAR;
  localparam int BUSY_END = DW + PAR + GP;
  localparam int IDLE_K   = BUSY_END + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [11:0]   req_data;
  logic [3:0]    ack;
  logic          ser_load;
  logic [DW-1:0] ser_din;
  logic          ser_dv;
  logic [1:0]    gnt_id;
  logic          busy;
  logic          done;
  logic          par_sel;
  logic          par_bit;

  logic [DW-1:0] sr;
  logic          dout_q;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [DW-1:0] W0 = 3'b011;
  localparam logic [DW-1:0] W1 = 3'b110;
  localparam logic [DW-1:0] W2 = 3'b101;
  localparam logic [DW-1:0] W3 = 3'b100;

  always #5 clk = ~clk;

  serial_tx_scheduler #(.N_REQ(4), .DATA_W(DW), .GAP(GP)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .ser_load(ser_load), .ser_din(ser_din), .ser_dv(ser_dv), .gnt_id(gnt_id),
    .busy(busy), .done(done), .par_sel(par_sel), .par_bit(par_bit)
  );

  // Serializer with a registered output stage: dout lags the load by two edges.
  always @(posedge clk) begin
    if (ser_load) sr <= ser_din;
    else          sr <= sr << 1;
    dout_q <= sr[DW-1];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ack"}, ack, 0);
    chk({tag, " ser_load"}, ser_load, 0);
    chk({tag, " ser_din"}, ser_din, 0);
    chk({tag, " ser_dv"}, ser_dv, 0);
    chk({tag, " gnt_id"}, gnt_id, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " par_sel"}, par_sel, 0);
    chk({tag, " par_bit"}, par_bit, 0);
  endtask

  task automatic wait_load();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ser_load && n < 20);
    if (!ser_load) chk("load_timeout", ser_load, 1);
  endtask

  // Entered on the LOAD cycle; walks the frame through its first idle cycle.
  task automatic frame(input int id, input logic [DW-1:0] word, input logic [3:0] nreq);
    logic [3:0] oh;
    logic       dv_e, last_e, par_e;
    oh = 4'b0001 << id;
    chk($sformatf("L%0d ser_load", id), ser_load, 1);
    chk($sformatf("L%0d ack", id), ack, oh);
    chk($sformatf("L%0d gnt_id", id), gnt_id, id);
    chk($sformatf("L%0d ser_din", id), ser_din, word);
    chk($sformatf("L%0d busy", id), busy, 1);
    req = nreq;
    for (int k = 1; k <= IDLE_K; k++) begin
      @(negedge clk);
      dv_e   = (k >= 2) && (k <= LAST_DV);
      last_e = (k == LAST_DV);
      par_e  = (PAR == 1) && (k == DW + 2);
      chk($sformatf("g%0d k%0d ser_dv", id, k), ser_dv, dv_e);
      chk($sformatf("g%0d k%0d done", id, k), done, last_e);
      chk($sformatf("g%0d k%0d par_sel", id, k), par_sel, par_e);
      chk($sformatf("g%0d k%0d par_bit", id, k), par_bit, par_e ? ^word : 1'b0);
      chk($sformatf("g%0d k%0d busy", id, k), busy, k <= BUSY_END);
      chk($sformatf("g%0d k%0d ack", id, k), ack, 0);
      chk($sformatf("g%0d k%0d ser_load", id, k), ser_load, 0);
      chk($sformatf("g%0d k%0d ser_din", id, k), ser_din, word);
      if (k >= 2 && k <= DW + 1)
        chk($sformatf("g%0d k%0d dout", id, k), dout_q, word[DW+1-k]);
    end
  endtask

  initial begin
    rst      = 1'b0;
    req      = 4'hF;
    req_data = {W3, W2, W1, W0};

    // Reset holds everything at zero even with all requests pending.
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rst = 1'b1;
    wait_load();
    frame(0, W0, 4'b0000);

    // Single requester 2 with word 101.
    req = 4'b0100;
    wait_load();
    frame(2, W2, 4'b0000);

    // Pointer at 2: search wraps past the idle requester 3 to 0, then 1.
    req = 4'b0011;
    wait_load();
    frame(0, W0, 4'b0011);
    wait_load();
    frame(1, W1, 4'b0000);

    // Reset during SHIFT bit 1 abandons the frame.
    req = 4'b0010;
    wait_load();
    chk("mr gnt_id", gnt_id, 1);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req = 4'hF;
    #1;
    chk_all_zero("mr");
    repeat (2) begin
      @(negedge clk);
      chk("mr hold done", done, 0);
      chk("mr hold busy", busy, 0);
      chk("mr hold ser_dv", ser_dv, 0);
    end
    rst = 1'b1;

    // Pointer back to 3: constant requests rotate 0,1,2,3,0.
    wait_load();
    frame(0, W0, 4'hF);
    wait_load();
    frame(1, W1, 4'hF);
    wait_load();
    frame(2, W2, 4'hF);
    wait_load();
    frame(3, W3, 4'hF);
    wait_load();
    frame(0, W0, 4'h0);

    repeat (3) @(negedge clk);
    chk("end busy", busy, 0);
    chk("end ack", ack, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
